// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - regfile write-port arbiter: priority pipeline writeback plus queued long-latency writeback (optional WB_STARVE_GUARD_EN)
module regfile_wb_arbiter #(
    parameter  int DATA_W     = 32,
    parameter  int ADDR_W     = 5,
    parameter  int DEPTH      = 4,
    parameter  int STARVE_LIM = 8,
    localparam int REG_NUM    = 2 ** ADDR_W,
    localparam int CW         = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_waddr,
    input  logic [DATA_W-1:0] a_wdata,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_waddr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0] wdata,
    output logic [REG_NUM-1:0] pend_mask,
    output logic [CW-1:0]     fifo_cnt,
    output logic              stall_req
);

    localparam int            PW   = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    // Pointer arithmetic relies on natural wrap, so DEPTH must be a power of two.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || STARVE_LIM < 1) begin : g_param_check
        $error("regfile_wb_arbiter: DEPTH must be a power of 2 >= 2 and STARVE_LIM >= 1");
    end

    logic [ADDR_W-1:0] mem_addr [DEPTH];
    logic [DATA_W-1:0] mem_data [DEPTH];
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [CW-1:0]     cnt;

    logic fifo_ne;
    logic a_sel;
    logic push;
    logic pop;

    // Writes to r0 are architecturally void: A to r0 is treated as idle, B to r0 is
    // handshaken but never stored.
    assign fifo_ne  = (cnt != '0);
    assign a_sel    = rst && a_we && (a_waddr != '0);
    assign b_ready  = rst && (cnt != FULL);
    assign push     = b_valid && b_ready && (b_waddr != '0);
    assign pop      = rst && !a_sel && fifo_ne;
    assign fifo_cnt = cnt;

    // Write-port mux: A first, otherwise the FIFO head (which pops on this edge).
    always_comb begin
        we    = 1'b0;
        waddr = '0;
        wdata = '0;
        if (a_sel) begin
            we    = 1'b1;
            waddr = a_waddr;
            wdata = a_wdata;
        end else if (pop) begin
            we    = 1'b1;
            waddr = mem_addr[rd_ptr];
            wdata = mem_data[rd_ptr];
        end
    end

    // FIFO pointers and occupancy; a concurrent push and pop leaves cnt unchanged.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // FIFO storage; contents need no reset because cnt marks which slots are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[wr_ptr] <= b_waddr;
            mem_data[wr_ptr] <= b_wdata;
        end
    end

    // Pending-write mask decoded from the live slots, so duplicates hold a bit until the last drains.
    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < cnt) begin
                pend_mask[mem_addr[rd_ptr + PW'(i)]] = 1'b1;
            end
        end
    end

`ifdef WB_STARVE_GUARD_EN
    localparam int            SW  = $clog2(STARVE_LIM + 1);
    localparam logic [SW-1:0] LIM = SW'(STARVE_LIM);

    logic [SW-1:0] starve_cnt;
    logic [SW-1:0] starve_nxt;
    logic          stall_q;

    // Count consecutive cycles the waiting head loses to A, saturating at the limit.
    always_comb begin
        starve_nxt = starve_cnt;
        if (pop || !fifo_ne) begin
            starve_nxt = '0;
        end else if (a_sel && starve_cnt != LIM) begin
            starve_nxt = starve_cnt + SW'(1);
        end
    end

    // stall_req rises with the edge that saturates the counter and falls with the head pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= '0;
            stall_q    <= 1'b0;
        end else begin
            starve_cnt <= starve_nxt;
            stall_q    <= (starve_nxt == LIM);
        end
    end

    assign stall_req = stall_q;
`else
    assign stall_req = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 4;
    localparam int LIM    = 8;
`ifdef WB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic              clk;
    logic              rst;
    logic              a_we;
    logic [ADDR_W-1:0] a_waddr;
    logic [DATA_W-1:0] a_wdata;
    logic              b_valid;
    logic              b_ready;
    logic [ADDR_W-1:0] b_waddr;
    logic [DATA_W-1:0] b_wdata;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic [31:0]       pend_mask;
    logic [2:0]        fifo_cnt;
    logic              stall_req;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } ent_t;

    regfile_wb_arbiter #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .STARVE_LIM(LIM)
    ) dut (
        .clk(clk), .rst(rst),
        .a_we(a_we), .a_waddr(a_waddr), .a_wdata(a_wdata),
        .b_valid(b_valid), .b_ready(b_ready), .b_waddr(b_waddr), .b_wdata(b_wdata),
        .we(we), .waddr(waddr), .wdata(wdata),
        .pend_mask(pend_mask), .fifo_cnt(fifo_cnt), .stall_req(stall_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        a_we = 0; a_waddr = 0; a_wdata = 0;
        b_valid = 0; b_waddr = 0; b_wdata = 0;
    endtask

    task automatic do_reset();
        rst = 0;
        idle_inputs();
        tick();
        tick();
        rst = 1;
    endtask

    task automatic test_reset();
        rst = 0;
        a_we = 1; a_waddr = 5; a_wdata = 32'h11;
        b_valid = 1; b_waddr = 3; b_wdata = 32'h33;
        tick();
        tick();
        #2;
        checks++;
        if ({we, waddr, wdata} !== '0) begin
            errors++; $display("FAIL reset_wport: got we=%b waddr=%0d wdata=%h want 0/0/0", we, waddr, wdata);
        end
        checks++;
        if ({b_ready, fifo_cnt, pend_mask, stall_req} !== '0) begin
            errors++; $display("FAIL reset_state: got rdy=%b cnt=%0d pend=%h stall=%b want all 0", b_ready, fifo_cnt, pend_mask, stall_req);
        end
        idle_inputs();
        rst = 1;
        #2;
        checks++;
        if (b_ready !== 1'b1 || fifo_cnt !== 3'd0 || we !== 1'b0) begin
            errors++; $display("FAIL reset_release: got rdy=%b cnt=%0d we=%b want 1/0/0", b_ready, fifo_cnt, we);
        end
        a_we = 1; a_waddr = 5; b_valid = 1; b_waddr = 3;
        tick();
        tick();
        idle_inputs();
        #2;
        checks++;
        if (fifo_cnt !== 3'd2 || we !== 1'b1 || waddr !== 5'd3) begin
            errors++; $display("FAIL middrain_setup: got cnt=%0d we=%b waddr=%0d want 2/1/3", fifo_cnt, we, waddr);
        end
        rst = 0;
        #1;
        checks++;
        if (fifo_cnt !== 3'd0 || we !== 1'b0 || pend_mask !== 32'h0) begin
            errors++; $display("FAIL middrain_reset: got cnt=%0d we=%b pend=%h want 0/0/0", fifo_cnt, we, pend_mask);
        end
        tick();
        rst = 1;
        #2;
        checks++;
        if (fifo_cnt !== 3'd0 || we !== 1'b0) begin
            errors++; $display("FAIL middrain_after: got cnt=%0d we=%b want 0/0", fifo_cnt, we);
        end
    endtask

    task automatic test_a_only();
        do_reset();
        a_we = 1; a_waddr = 5; a_wdata = 32'h11;
        #2;
        checks++;
        if ({we, waddr, wdata} !== {1'b1, 5'd5, 32'h11}) begin
            errors++; $display("FAIL a_only_write: got we=%b waddr=%0d wdata=%h want 1/5/11", we, waddr, wdata);
        end
        a_waddr = 0;
        #2;
        checks++;
        if (we !== 1'b0) begin
            errors++; $display("FAIL a_only_r0: got we=%b want 0", we);
        end
        idle_inputs();
    endtask

    task automatic test_b_only();
        do_reset();
        b_valid = 1; b_waddr = 7; b_wdata = 32'hDEAD;
        #2;
        checks++;
        if (b_ready !== 1'b1 || we !== 1'b0) begin
            errors++; $display("FAIL b_only_accept: got rdy=%b we=%b want 1/0", b_ready, we);
        end
        tick();
        b_valid = 0;
        #2;
        checks++;
        if ({we, waddr, wdata} !== {1'b1, 5'd7, 32'hDEAD} || pend_mask !== 32'h80 || fifo_cnt !== 3'd1) begin
            errors++; $display("FAIL b_only_cycle1: got we=%b waddr=%0d wdata=%h pend=%h cnt=%0d want 1/7/dead/80/1", we, waddr, wdata, pend_mask, fifo_cnt);
        end
        tick();
        #2;
        checks++;
        if (we !== 1'b0 || pend_mask !== 32'h0 || fifo_cnt !== 3'd0) begin
            errors++; $display("FAIL b_only_cycle2: got we=%b pend=%h cnt=%0d want 0/0/0", we, pend_mask, fifo_cnt);
        end
    endtask

    task automatic test_contention();
        int k;
        do_reset();
        k = 1;
        for (int c = 0; c < 10; c++) begin
            a_we = 1; a_waddr = 5'($urandom_range(1, 31)); a_wdata = $urandom;
            b_valid = 1; b_waddr = 5'(k); b_wdata = 32'h100 * k;
            #2;
            checks++;
            if ({we, waddr, wdata} !== {1'b1, a_waddr, a_wdata}) begin
                errors++; $display("FAIL contention_a_wins c=%0d: got we=%b waddr=%0d want 1/%0d", c, we, waddr, a_waddr);
            end
            if (b_ready) k++;
            tick();
        end
        #2;
        checks++;
        if (k !== 5 || b_ready !== 1'b0 || fifo_cnt !== 3'd4 || pend_mask !== 32'h1E) begin
            errors++; $display("FAIL contention_full: got next=%0d rdy=%b cnt=%0d pend=%h want 5/0/4/1e", k, b_ready, fifo_cnt, pend_mask);
        end
        a_we = 0;
        for (int j = 1; j <= 5; j++) begin
            #2;
            checks++;
            if ({we, waddr, wdata} !== {1'b1, 5'(j), 32'h100 * j}) begin
                errors++; $display("FAIL contention_drain j=%0d: got we=%b waddr=%0d wdata=%h", j, we, waddr, wdata);
            end
            if (j == 1) begin
                checks++;
                if (b_ready !== 1'b0) begin
                    errors++; $display("FAIL contention_no_credit: got rdy=%b want 0", b_ready);
                end
            end
            if (j == 2) begin
                checks++;
                if (b_ready !== 1'b1) begin
                    errors++; $display("FAIL contention_r5_accept: got rdy=%b want 1", b_ready);
                end
            end
            tick();
            if (j == 2) b_valid = 0;
        end
        #2;
        checks++;
        if (we !== 1'b0 || fifo_cnt !== 3'd0) begin
            errors++; $display("FAIL contention_empty: got we=%b cnt=%0d want 0/0", we, fifo_cnt);
        end
    endtask

    task automatic test_r0_wrap();
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        int n;
        do_reset();
        b_valid = 1; b_waddr = 0; b_wdata = 32'h123;
        #2;
        checks++;
        if (b_ready !== 1'b1) begin
            errors++; $display("FAIL r0_ready: got %b want 1", b_ready);
        end
        tick();
        b_valid = 0;
        #2;
        checks++;
        if (fifo_cnt !== 3'd0 || we !== 1'b0 || pend_mask !== 32'h0) begin
            errors++; $display("FAIL r0_dropped: got cnt=%0d we=%b pend=%h want 0/0/0", fifo_cnt, we, pend_mask);
        end
        for (int i = 0; i < 9; i++) begin
            addr = 5'((i * 7) % 31 + 1);
            data = $urandom;
            b_valid = 1; b_waddr = addr; b_wdata = data;
            a_we = 1; a_waddr = 5'($urandom_range(1, 31)); a_wdata = $urandom;
            #2;
            checks++;
            if (waddr !== a_waddr) begin
                errors++; $display("FAIL wrap_a_push i=%0d: got waddr=%0d want %0d", i, waddr, a_waddr);
            end
            tick();
            b_valid = 0;
            n = $urandom_range(0, 2);
            for (int b = 0; b < n; b++) begin
                a_waddr = 5'($urandom_range(1, 31)); a_wdata = $urandom;
                #2;
                checks++;
                if (waddr !== a_waddr || pend_mask[addr] !== 1'b1) begin
                    errors++; $display("FAIL wrap_a_burst i=%0d: got waddr=%0d pend=%h want %0d with bit %0d", i, waddr, pend_mask, a_waddr, addr);
                end
                tick();
            end
            a_we = 1'(i % 2); a_waddr = 0;
            #2;
            checks++;
            if ({we, waddr, wdata} !== {1'b1, addr, data}) begin
                errors++; $display("FAIL wrap_drain i=%0d: got we=%b waddr=%0d wdata=%h want 1/%0d/%h", i, we, waddr, wdata, addr, data);
            end
            tick();
        end
        idle_inputs();
        #2;
        checks++;
        if (fifo_cnt !== 3'd0) begin
            errors++; $display("FAIL wrap_empty: got cnt=%0d want 0", fifo_cnt);
        end
    endtask

    task automatic test_starve();
        do_reset();
        a_we = 1; a_waddr = 9; a_wdata = 32'h99;
        b_valid = 1; b_waddr = 3; b_wdata = 32'h3333;
        tick();
        b_valid = 0;
        for (int c = 1; c <= 8; c++) begin
            #2;
            checks++;
            if (stall_req !== 1'b0 || waddr !== 5'd9) begin
                errors++; $display("FAIL starve_early c=%0d: got stall=%b waddr=%0d want 0/9", c, stall_req, waddr);
            end
            tick();
        end
        #2;
        checks++;
        if (stall_req !== GUARD || waddr !== 5'd9) begin
            errors++; $display("FAIL starve_cycle9: got stall=%b waddr=%0d want %b/9", stall_req, waddr, GUARD);
        end
        a_we = 0;
        #2;
        checks++;
        if ({we, waddr, wdata} !== {1'b1, 5'd3, 32'h3333}) begin
            errors++; $display("FAIL starve_drain: got we=%b waddr=%0d wdata=%h want 1/3/3333", we, waddr, wdata);
        end
        tick();
        #2;
        checks++;
        if (stall_req !== 1'b0 || fifo_cnt !== 3'd0) begin
            errors++; $display("FAIL starve_release: got stall=%b cnt=%0d want 0/0", stall_req, fifo_cnt);
        end
    endtask

    task automatic test_random();
        ent_t q[$];
        int   run;
        bit   exp_stall;
        do_reset();
        run = 0;
        exp_stall = 0;
        for (int c = 0; c < 400; c++) begin
            int   sz;
            bit   asel;
            bit   rdy;
            bit   pp;
            logic [31:0] ep;
            logic [ADDR_W-1:0] ea;
            logic [DATA_W-1:0] ed;
            a_we    = ($urandom_range(0, 9) < 5);
            a_waddr = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            a_wdata = $urandom;
            b_valid = ($urandom_range(0, 9) < 6);
            b_waddr = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 6));
            b_wdata = $urandom;
            #2;
            sz   = q.size();
            asel = a_we && (a_waddr != 0);
            rdy  = (sz < DEPTH);
            pp   = !asel && (sz > 0);
            ep   = '0;
            foreach (q[j]) ep[q[j].a] = 1'b1;
            ea = asel ? a_waddr : (pp ? q[0].a : 5'd0);
            ed = asel ? a_wdata : (pp ? q[0].d : 32'd0);
            checks++;
            if ({we, waddr, wdata} !== {asel | pp, ea, ed}) begin
                errors++; $display("FAIL rand_wport c=%0d: got %b/%0d/%h want %b/%0d/%h", c, we, waddr, wdata, asel | pp, ea, ed);
            end
            checks++;
            if (b_ready !== rdy || fifo_cnt !== 3'(sz)) begin
                errors++; $display("FAIL rand_occupancy c=%0d: got rdy=%b cnt=%0d want %b/%0d", c, b_ready, fifo_cnt, rdy, sz);
            end
            checks++;
            if (pend_mask !== ep) begin
                errors++; $display("FAIL rand_pend c=%0d: got %h want %h", c, pend_mask, ep);
            end
            checks++;
            if (stall_req !== exp_stall) begin
                errors++; $display("FAIL rand_stall c=%0d: got %b want %b", c, stall_req, exp_stall);
            end
            if (pp) q.delete(0);
            if (b_valid && rdy && b_waddr != 0) q.push_back('{b_waddr, b_wdata});
            if (pp || sz == 0) run = 0;
            else if (asel && run < LIM) run++;
            exp_stall = GUARD && (run >= LIM);
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        rst = 0;
        idle_inputs();
        test_reset();
        test_a_only();
        test_b_only();
        test_contention();
        test_r0_wrap();
        test_starve();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
